uart_frame_ctrl: RTL and testbench

Parametrised command/response framer between a byte-level UART core (rx_rdy/rx_data/clr_rx_rdy, trmt/tx_data/tx_done) and the command processor. It assembles CMD_BYTES received bytes, MSB first, into one command word with a cmd_rdy/clr_cmd_rdy handshake and flags overrun. It serialises a RESP_BYTES response, MSB first, over the TX handshake. An optional inter-byte timeout resynchronises partial frames.

---
 rtl/uart_frame_ctrl.sv | 153 +++++++++++++++
 tb/tb_uart_frame_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_ctrl.sv
// Command/response framer between a byte-level UART core and a command processor.
// Optional inter-byte timeout enabled by defining CMD_TIMEOUT_EN.
module uart_frame_ctrl #(
  parameter int CMD_BYTES      = 2,
  parameter int RESP_BYTES     = 1,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rx_rdy,
  input  logic [7:0]              rx_data,
  output logic                    clr_rx_rdy,
  output logic [8*CMD_BYTES-1:0]  cmd,
  output logic                    cmd_rdy,
  input  logic                    clr_cmd_rdy,
  output logic                    overrun,
  output logic                    frame_err,
  input  logic                    resp_send,
  input  logic [8*RESP_BYTES-1:0] resp,
  output logic                    resp_busy,
  output logic                    resp_done,
  output logic                    trmt,
  output logic [7:0]              tx_data,
  input  logic                    tx_done
);

  localparam int         CW       = 8 * CMD_BYTES;
  localparam int         RW       = 8 * RESP_BYTES;
  localparam logic [3:0] LAST_IDX = 4'(CMD_BYTES - 1);
  localparam logic [3:0] RESP_N   = 4'(RESP_BYTES);

  if (CMD_BYTES < 1 || CMD_BYTES > 8 || RESP_BYTES < 1 || RESP_BYTES > 8 ||
      TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("uart_frame_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_WAIT} tx_state_t;

  logic [CW-1:0] assy;
  logic [CW-1:0] assy_next;
  logic [3:0]    byte_cnt;
  logic          last_byte;
  logic          tmo_hit;

  // The UART byte is consumed in the same cycle it is presented.
  assign clr_rx_rdy = rx_rdy;
  assign assy_next  = CW'({assy, rx_data});
  assign last_byte  = rx_rdy && (byte_cnt == LAST_IDX);

`ifdef CMD_TIMEOUT_EN
  localparam int            TW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_cnt;

  // An arriving byte in the expiry cycle takes priority over the timeout.
  assign tmo_hit = !rx_rdy && (byte_cnt != 4'd0) && (tmo_cnt == TMO_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt   <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= tmo_hit;
      if (rx_rdy || byte_cnt == 4'd0 || tmo_hit) tmo_cnt <= '0;
      else                                       tmo_cnt <= tmo_cnt + TW'(1);
    end
  end
`else
  assign tmo_hit   = 1'b0;
  assign frame_err = 1'b0;
`endif

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      assy     <= '0;
      byte_cnt <= 4'd0;
      cmd      <= '0;
      cmd_rdy  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (rx_rdy) begin
        assy     <= assy_next;
        byte_cnt <= last_byte ? 4'd0 : byte_cnt + 4'd1;
      end else if (tmo_hit) begin
        byte_cnt <= 4'd0;
      end

      if (last_byte) cmd <= assy_next;

      // A completion outranks a same-cycle clear; that pairing is not an overrun.
      if (last_byte)        cmd_rdy <= 1'b1;
      else if (clr_cmd_rdy) cmd_rdy <= 1'b0;

      if (clr_cmd_rdy)                overrun <= 1'b0;
      else if (last_byte && cmd_rdy)  overrun <= 1'b1;
    end
  end

  tx_state_t     tx_state;
  logic [RW-1:0] shreg;
  logic [RW-1:0] sh_next;
  logic [3:0]    bytes_left;

  assign sh_next = shreg << 8;

  // trmt/tx_data are loaded on entry to TX_SEND so they are registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state   <= TX_IDLE;
      shreg      <= '0;
      bytes_left <= 4'd0;
      trmt       <= 1'b0;
      tx_data    <= 8'h00;
      resp_busy  <= 1'b0;
      resp_done  <= 1'b0;
    end else begin
      trmt      <= 1'b0;
      resp_done <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (resp_send) begin
            shreg      <= resp;
            bytes_left <= RESP_N;
            resp_busy  <= 1'b1;
            trmt       <= 1'b1;
            tx_data    <= resp[RW-1 -: 8];
            tx_state   <= TX_SEND;
          end
        end
        TX_SEND: tx_state <= TX_WAIT;
        TX_WAIT: begin
          if (tx_done) begin
            shreg      <= sh_next;
            bytes_left <= bytes_left - 4'd1;
            if (bytes_left == 4'd1) begin
              resp_done <= 1'b1;
              resp_busy <= 1'b0;
              tx_state  <= TX_IDLE;
            end else begin
              trmt     <= 1'b1;
              tx_data  <= sh_next[RW-1 -: 8];
              tx_state <= TX_SEND;
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Self-checking bench: a 2-byte-cmd/2-byte-resp and a 3-byte-cmd/1-byte-resp
// framer share one stimulus stream and are compared to a byte-list reference model.
module tb_uart_frame_ctrl;

  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_cmd_rdy;
  logic        resp_send;
  logic [15:0] resp;
  logic        tx_done_a, tx_done_b;

  logic        clr_rx_rdy_a, cmd_rdy_a, overrun_a, frame_err_a, resp_busy_a, resp_done_a, trmt_a;
  logic [15:0] cmd_a;
  logic [7:0]  tx_data_a;
  logic        clr_rx_rdy_b, cmd_rdy_b, overrun_b, frame_err_b, resp_busy_b, resp_done_b, trmt_b;
  logic [23:0] cmd_b;
  logic [7:0]  tx_data_b;

  always #5 clk = ~clk;

  uart_frame_ctrl #(.CMD_BYTES(2), .RESP_BYTES(2), .TIMEOUT_CYCLES(TMO)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data), .clr_rx_rdy(clr_rx_rdy_a),
    .cmd(cmd_a), .cmd_rdy(cmd_rdy_a), .clr_cmd_rdy(clr_cmd_rdy), .overrun(overrun_a),
    .frame_err(frame_err_a), .resp_send(resp_send), .resp(resp), .resp_busy(resp_busy_a),
    .resp_done(resp_done_a), .trmt(trmt_a), .tx_data(tx_data_a), .tx_done(tx_done_a));

  uart_frame_ctrl #(.CMD_BYTES(3), .RESP_BYTES(1), .TIMEOUT_CYCLES(TMO)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data), .clr_rx_rdy(clr_rx_rdy_b),
    .cmd(cmd_b), .cmd_rdy(cmd_rdy_b), .clr_cmd_rdy(clr_cmd_rdy), .overrun(overrun_b),
    .frame_err(frame_err_b), .resp_send(resp_send), .resp(resp[7:0]), .resp_busy(resp_busy_b),
    .resp_done(resp_done_b), .trmt(trmt_b), .tx_data(tx_data_b), .tx_done(tx_done_b));

  int errors = 0;
  int checks = 0;

  // Reference model state, index 0 = instance a, 1 = instance b.
  logic [63:0] m_cmd [2];
  bit          m_rdy [2], m_ovr [2], m_fe [2];
  logic [7:0]  m_part [2][8];
  int          m_pc [2], m_idle [2];
  bit          m_busy [2], m_trmt [2], m_done [2];
  logic [7:0]  m_txb [2][8];
  int          m_txi [2];
  logic [7:0]  m_cur [2];
  // UART transmitter model.
  bit          tdv [2];
  int          dly [2];

  function automatic int cb(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic int rb(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cmd[k] = '0; m_rdy[k] = 0; m_ovr[k] = 0; m_fe[k] = 0;
      m_pc[k] = 0; m_idle[k] = 0;
      m_busy[k] = 0; m_trmt[k] = 0; m_done[k] = 0; m_txi[k] = 0; m_cur[k] = 8'h00;
    end
  endtask

  task automatic cmp_inst(input int k, input logic [63:0] cmdv, input logic rdy, input logic ovr,
                          input logic fe, input logic busy, input logic done, input logic tr,
                          input logic [7:0] txd);
    chk($sformatf("cmd_%0d", k), cmdv, m_cmd[k]);
    chk($sformatf("cmd_rdy_%0d", k), 64'(rdy), 64'(m_rdy[k]));
    chk($sformatf("overrun_%0d", k), 64'(ovr), 64'(m_ovr[k]));
    chk($sformatf("frame_err_%0d", k), 64'(fe), 64'(m_fe[k]));
    chk($sformatf("resp_busy_%0d", k), 64'(busy), 64'(m_busy[k]));
    chk($sformatf("resp_done_%0d", k), 64'(done), 64'(m_done[k]));
    chk($sformatf("trmt_%0d", k), 64'(tr), 64'(m_trmt[k]));
    if (m_busy[k]) chk($sformatf("tx_data_%0d", k), 64'(txd), 64'(m_cur[k]));
  endtask

  // One clock: check the combinational consume, advance models across the edge, compare.
  task automatic step();
    logic        rx_r, clr, snd;
    logic [7:0]  rxd;
    logic [15:0] rsp;
    logic [1:0]  dut_tr, pre_td;
    rx_r = rx_rdy; rxd = rx_data; clr = clr_cmd_rdy; snd = resp_send; rsp = resp;
    dut_tr = {trmt_b, trmt_a};
    pre_td = {tx_done_b, tx_done_a};
    chk("clr_rx_rdy_a", 64'(clr_rx_rdy_a), 64'(rx_r));
    chk("clr_rx_rdy_b", 64'(clr_rx_rdy_b), 64'(rx_r));
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      bit          old_rdy, prev_tr, complete;
      logic [63:0] c;
      complete = 0;
      c = '0;
      m_fe[k] = 0;
      if (rx_r) begin
        m_part[k][m_pc[k]] = rxd;
        m_pc[k]++;
        m_idle[k] = 0;
        if (m_pc[k] == cb(k)) begin
          for (int i = 0; i < cb(k); i++) c = (c << 8) | 64'(m_part[k][i]);
          complete = 1;
          m_pc[k] = 0;
        end
      end else if (m_pc[k] != 0) begin
`ifdef CMD_TIMEOUT_EN
        m_idle[k]++;
        if (m_idle[k] == TMO) begin
          m_pc[k] = 0; m_idle[k] = 0; m_fe[k] = 1;
        end
`endif
      end
      old_rdy = m_rdy[k];
      if (clr) begin m_rdy[k] = 0; m_ovr[k] = 0; end
      if (complete) begin
        if (old_rdy && !clr) m_ovr[k] = 1;
        m_rdy[k] = 1;
        m_cmd[k] = c;
      end

      prev_tr = m_trmt[k];
      m_trmt[k] = 0;
      m_done[k] = 0;
      if (!m_busy[k]) begin
        if (snd) begin
          for (int i = 0; i < rb(k); i++) m_txb[k][i] = 8'(rsp >> (8 * (rb(k) - 1 - i)));
          m_busy[k] = 1; m_txi[k] = 1; m_cur[k] = m_txb[k][0]; m_trmt[k] = 1;
        end
      end else if (pre_td[k] && !prev_tr) begin
        if (m_txi[k] < rb(k)) begin
          m_cur[k] = m_txb[k][m_txi[k]];
          m_txi[k]++;
          m_trmt[k] = 1;
        end else begin
          m_busy[k] = 0; m_done[k] = 1;
        end
      end

      if (dut_tr[k]) begin
        tdv[k] = 0; dly[k] = $urandom_range(1, 5);
      end else if (dly[k] > 0) begin
        dly[k]--;
        if (dly[k] == 0) tdv[k] = 1;
      end
    end
    tx_done_a = tdv[0];
    tx_done_b = tdv[1];
    cmp_inst(0, 64'(cmd_a), cmd_rdy_a, overrun_a, frame_err_a, resp_busy_a, resp_done_a, trmt_a, tx_data_a);
    cmp_inst(1, 64'(cmd_b), cmd_rdy_b, overrun_b, frame_err_b, resp_busy_b, resp_done_b, trmt_b, tx_data_b);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_rdy = 1'b1; rx_data = b;
    step();
    rx_rdy = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear at once.
  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk({tag, "_outs_a"}, 64'({cmd_a, cmd_rdy_a, overrun_a, frame_err_a, clr_rx_rdy_a,
                               resp_busy_a, resp_done_a, trmt_a, tx_data_a}), 64'h0);
    chk({tag, "_outs_b"}, 64'({cmd_b, cmd_rdy_b, overrun_b, frame_err_b, clr_rx_rdy_b,
                               resp_busy_b, resp_done_b, trmt_b, tx_data_b}), 64'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int         n_tr, n_done, fe_cnt;
    logic [7:0] tx_seen [4];

    rst_n = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00; clr_cmd_rdy = 1'b0;
    resp_send = 1'b0; resp = 16'h0000;
    tdv[0] = 1; tdv[1] = 1; dly[0] = 0; dly[1] = 0;
    tx_done_a = 1'b1; tx_done_b = 1'b1;
    @(posedge clk);
    #1;
    do_reset("reset");
    idle(2);

    // 2-byte command, then clear.
    send_byte(8'hA5);
    chk("t1_rdy_after_first", 64'(cmd_rdy_a), 64'h0);
    send_byte(8'h3C);
    chk("t1_cmd", 64'(cmd_a), 64'hA53C);
    chk("t1_rdy", 64'(cmd_rdy_a), 64'h1);
    clr_cmd_rdy = 1'b1; step(); clr_cmd_rdy = 1'b0;
    chk("t1_clr", 64'(cmd_rdy_a), 64'h0);

    // 3-byte commands and overrun.
    do_reset("realign");
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
    chk("t2_cmd", 64'(cmd_b), 64'h123456);
    send_byte(8'hFF); send_byte(8'hEE); send_byte(8'hDD);
    chk("t2_cmd_ovr", 64'(cmd_b), 64'hFFEEDD);
    chk("t2_overrun", 64'(overrun_b), 64'h1);
    chk("t2_rdy_held", 64'(cmd_rdy_b), 64'h1);
    clr_cmd_rdy = 1'b1; step(); clr_cmd_rdy = 1'b0;
    chk("t2_flags_clr", 64'({cmd_rdy_b, overrun_b}), 64'h0);

    // Completion and clear in the same cycle.
    send_byte(8'h0A); send_byte(8'h0B); send_byte(8'h0C);
    send_byte(8'h0D); send_byte(8'h0E);
    clr_cmd_rdy = 1'b1; send_byte(8'h0F); clr_cmd_rdy = 1'b0;
    chk("t3_rdy", 64'(cmd_rdy_b), 64'h1);
    chk("t3_no_ovr", 64'(overrun_b), 64'h0);
    chk("t3_cmd", 64'(cmd_b), 64'h0D0E0F);

    // Two-byte response with a resend attempt while busy.
    resp = 16'hBEEF;
    n_tr = 0; n_done = 0;
    for (int i = 0; i < 40; i++) begin
      resp_send = (i == 0 || i == 3);
      step();
      if (trmt_a) begin
        if (n_tr < 4) tx_seen[n_tr] = tx_data_a;
        n_tr++;
      end
      if (resp_done_a) n_done++;
    end
    resp_send = 1'b0;
    chk("t4_trmt_count", 64'(n_tr), 64'd2);
    if (n_tr >= 2) begin
      chk("t4_byte0", 64'(tx_seen[0]), 64'hBE);
      chk("t4_byte1", 64'(tx_seen[1]), 64'hEF);
    end
    chk("t4_done_pulses", 64'(n_done), 64'd1);
    idle(10);
    chk("t4_idle", 64'({resp_busy_a, resp_busy_b}), 64'h0);

    // Inter-byte gap longer than the timeout.
    do_reset("pre_tmo");
    send_byte(8'h11);
    fe_cnt = 0;
    for (int i = 0; i < 120; i++) begin
      step();
      if (frame_err_a) fe_cnt++;
    end
`ifdef CMD_TIMEOUT_EN
    chk("t5_fe_pulses", 64'(fe_cnt), 64'd1);
    send_byte(8'h22); send_byte(8'h33);
    chk("t5_cmd", 64'(cmd_a), 64'h2233);
`else
    chk("t5_fe_pulses", 64'(fe_cnt), 64'd0);
    send_byte(8'h22);
    chk("t5_cmd", 64'(cmd_a), 64'h1122);
`endif

    // Reset mid-frame and mid-response.
    do_reset("pre_t6");
    send_byte(8'h01);
    do_reset("mid_frame");
    resp = 16'h1234; resp_send = 1'b1; step(); resp_send = 1'b0;
    step();
    do_reset("mid_tx");
    idle(10);
    send_byte(8'h01); send_byte(8'h02);
    chk("t6_cmd", 64'(cmd_a), 64'h0102);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rx_rdy      = ($urandom_range(0, 3) == 0);
      rx_data     = 8'($urandom);
      clr_cmd_rdy = ($urandom_range(0, 7) == 0);
      resp_send   = ($urandom_range(0, 15) == 0);
      resp        = 16'($urandom);
      step();
    end
    rx_rdy = 1'b0; clr_cmd_rdy = 1'b0; resp_send = 1'b0;
    idle(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
